// File: rtl/dram_config_sequencer.sv
// Boot-time configuration sequencer for the DRAM controller: plays the 11-byte
// CONFn/CSn write protocol after reset, then passes CPU requests straight through.
module dram_config_sequencer #(
    parameter logic [87:0] CFG_BYTES      = 88'h00_01_02_01_02_02_01_01_27_01_86,
    parameter int          STARTUP_CYCLES = 4,
    parameter int          STROBE_CYCLES  = 1,
    parameter int          GAP_CYCLES     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_csn_i,
    input  logic        cpu_rwn_i,
    input  logic [17:0] cpu_addr_i,
    input  logic        cfg_start_i,
    output logic        cpu_rdy_o,
    output logic        cfg_done_o,
    output logic        ctrl_csn_o,
    output logic        ctrl_rwn_o,
    output logic        ctrl_confn_o,
    output logic [17:0] ctrl_addr_o,
    input  logic        ctrl_rdy_i
);

    localparam int CNT_MAX = (STARTUP_CYCLES > STROBE_CYCLES)
                             ? ((STARTUP_CYCLES > GAP_CYCLES) ? STARTUP_CYCLES : GAP_CYCLES)
                             : ((STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES);
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_WAIT,
        S_STROBE,
        S_GAP,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t             state;
    logic [3:0]         step;
    logic [CNT_W-1:0]   cnt;
    logic               pending;
    logic               seq_csn;
    logic               seq_confn;
    logic [17:0]        seq_addr;
    logic               in_run;

    function automatic logic [7:0] cfg_byte(input logic [3:0] k);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 11; i++) begin
            if (k == 4'(i)) b = CFG_BYTES[8*i +: 8];
        end
        return b;
    endfunction

    // Sequencer outputs are registered alongside the next state so the
    // controller sees glitch-free CONFn/CSn/address during configuration.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_WAIT;
            step      <= 4'd0;
            cnt       <= '0;
            pending   <= 1'b0;
            seq_csn   <= 1'b1;
            seq_confn <= 1'b1;
            seq_addr  <= 18'd0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (cnt == CNT_W'(STARTUP_CYCLES)) begin
                        state     <= S_STROBE;
                        cnt       <= '0;
                        step      <= 4'd0;
                        seq_csn   <= 1'b0;
                        seq_confn <= 1'b0;
                        seq_addr  <= {10'b0, cfg_byte(4'd0)};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STROBE: begin
                    if (cnt == CNT_W'(STROBE_CYCLES - 1)) begin
                        state   <= S_GAP;
                        cnt     <= '0;
                        seq_csn <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt <= '0;
                        if (step == 4'd10) begin
                            state     <= S_SETTLE;
                            seq_confn <= 1'b1;
                            seq_addr  <= 18'd0;
                        end else begin
                            state    <= S_STROBE;
                            step     <= step + 4'd1;
                            seq_csn  <= 1'b0;
                            seq_addr <= {10'b0, cfg_byte(step + 4'd1)};
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= S_RUN;
                        step  <= 4'd0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // A re-run waits for any CPU access in flight to finish first.
                    if ((pending || cfg_start_i) && cpu_csn_i) begin
                        pending   <= 1'b0;
                        state     <= S_STROBE;
                        step      <= 4'd0;
                        cnt       <= '0;
                        seq_csn   <= 1'b0;
                        seq_confn <= 1'b0;
                        seq_addr  <= {10'b0, cfg_byte(4'd0)};
                    end else if (cfg_start_i) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state <= S_WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign in_run       = (state == S_RUN);
    assign ctrl_csn_o   = in_run ? cpu_csn_i  : seq_csn;
    assign ctrl_rwn_o   = in_run ? cpu_rwn_i  : 1'b1;
    assign ctrl_confn_o = in_run ? 1'b1       : seq_confn;
    assign ctrl_addr_o  = in_run ? cpu_addr_i : seq_addr;
    assign cpu_rdy_o    = in_run & (ctrl_rdy_i ^ CFG_BYTES[20]);
    assign cfg_done_o   = in_run;

endmodule
